// File: rtl/lfsr_twinkle_if.sv
// Handshake/status bundle between the LFSR twinkle stage and its neighbours.
// master: LFSR/top-level side; slave: lfsr_twinkle.
interface lfsr_twinkle_if #(
  parameter int N_LEDS = 8
);
  logic              enable;
  logic [3:0]        lfsr;
  logic [N_LEDS-1:0] led;
  logic              busy;
  logic [3:0]        cur_idx;

  modport master (
    output enable, lfsr,
    input  led, busy, cur_idx
  );

  modport slave (
    input  enable, lfsr,
    output led, busy, cur_idx
  );
endinterface

// File: rtl/lfsr_twinkle.sv
// Picks one LED from the LFSR word, fades it up, holds, fades down, then repeats.
// Optional macro TWINKLE_GAMMA_EN: quadratic PWM compare (level*level against a 2*PWM_BITS counter).
module lfsr_twinkle #(
  parameter int N_LEDS     = 8,
  parameter int PWM_BITS   = 4,
  parameter int TICK_DIV   = 1024,
  parameter int HOLD_TICKS = 8
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_twinkle_if.slave bus
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HC_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
`ifdef TWINKLE_GAMMA_EN
  localparam int CNT_W = 2 * PWM_BITS;
`else
  localparam int CNT_W = PWM_BITS;
`endif

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [HC_W-1:0]     HOLD_LAST = HC_W'(HOLD_TICKS - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_t;

  state_t              state, state_n;
  logic [PRE_W-1:0]    prescaler;
  logic [CNT_W-1:0]    pwm_cnt;
  logic [PWM_BITS-1:0] level, level_n;
  logic [HC_W-1:0]     hold_cnt, hold_n;
  logic [3:0]          cur_idx, idx_n;
  logic [3:0]          last_idx, last_n;
  logic                tick;
  logic [CNT_W-1:0]    thr;
  logic [N_LEDS-1:0]   lit_p0;

  // Fold the 4-bit word onto N_LEDS outputs and never repeat the previous LED.
  function automatic logic [3:0] pick_idx(input logic [3:0] word, input logic [3:0] last);
    logic [4:0] raw;
    raw = (5'(word) < 5'(N_LEDS)) ? 5'(word) : 5'(word) - 5'(N_LEDS);
    if (raw[3:0] == last) begin
      raw = (raw + 5'd1 == 5'(N_LEDS)) ? 5'd0 : raw + 5'd1;
    end
    return raw[3:0];
  endfunction

  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      pwm_cnt   <= pwm_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    hold_n  = hold_cnt;
    idx_n   = cur_idx;
    last_n  = last_idx;
    if (tick) begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            idx_n   = pick_idx(bus.lfsr, last_idx);
            level_n = '0;
            state_n = RISE;
          end
        end
        RISE: begin
          level_n = level + PWM_BITS'(1);
          if (level_n == LVL_MAX) begin
            hold_n  = '0;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) state_n = FALL;
          else                       hold_n  = hold_cnt + HC_W'(1);
        end
        FALL: begin
          level_n = level - PWM_BITS'(1);
          if (level_n == '0) begin
            last_n  = cur_idx;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      level    <= '0;
      hold_cnt <= '0;
      cur_idx  <= '0;
      last_idx <= '0;
    end else begin
      state    <= state_n;
      level    <= level_n;
      hold_cnt <= hold_n;
      cur_idx  <= idx_n;
      last_idx <= last_n;
    end
  end

  always_comb begin
`ifdef TWINKLE_GAMMA_EN
    thr = CNT_W'(level) * CNT_W'(level);
`else
    thr = level;
`endif
    lit_p0 = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      lit_p0[i] = (state != IDLE) && (cur_idx == 4'(i)) && (pwm_cnt < thr);
    end
  end

  // p0 -> p1: registered LED drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.led <= '0;
    else       bus.led <= lit_p0;
  end

  assign bus.busy    = (state != IDLE);
  assign bus.cur_idx = cur_idx;

endmodule

// File: tb/tb_lfsr_twinkle.sv
// Scoreboard bench for lfsr_twinkle: expected picks queued at stimulus, checked per twinkle.
// Small config: TICK_DIV=4, HOLD_TICKS=2, N_LEDS=8, PWM_BITS=4.
module tb_lfsr_twinkle;
  localparam int NL = 8;
  localparam int TD = 4;
  localparam int HT = 2;
  localparam int MX = 15;
  localparam int TWINKLE_CLKS = (MX + HT + MX) * TD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc;
  int   exp_q[$];
  int   exp_last = 0;

  int   active = 0, rise_cyc = 0, fall_cyc = 0, mon_idx = 0;
  int   lit = 0, stray = 0, idle_led = 0, busy_clks = 0, done_cnt = 0;

  lfsr_twinkle_if #(.N_LEDS(NL)) bus ();

  lfsr_twinkle #(
    .N_LEDS(NL), .PWM_BITS(4), .TICK_DIV(TD), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int map_idx(input int word, input int last);
    int raw;
    raw = (word < NL) ? word : word - NL;
    return (raw == last) ? (raw + 1) % NL : raw;
  endfunction

  // Level as a function of clocks since the pick edge, straight from the tick schedule.
  function automatic int level_at(input int d);
    if (d < MX * TD)               return d / TD;
    if (d < (MX + HT + 1) * TD)    return MX;
    return MX - (d - (MX + HT) * TD) / TD;
  endfunction

  function automatic int exp_lit(input int p);
    int n = 0;
    for (int d = 0; d < TWINKLE_CLKS; d++) begin
`ifdef TWINKLE_GAMMA_EN
      if (((p + d) % 256) < level_at(d) * level_at(d)) n++;
`else
      if (((p + d) % 16) < level_at(d)) n++;
`endif
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    logic [NL-1:0] mask;
    if (reset) begin
      active = 0;
    end else begin
      if (bus.busy) busy_clks++;
      if (active == 0 && bus.busy) begin
        active   = 1;
        rise_cyc = cyc;
        mon_idx  = int'(bus.cur_idx);
        lit      = 0;
        stray    = 0;
        check_val("pick_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_val("cur_idx", mon_idx, exp_q.pop_front());
      end
      if (active != 0) begin
        mask = NL'(1) << mon_idx;
        if (bus.led[mon_idx]) lit++;
        if ((bus.led & ~mask) != '0) stray++;
        if (!bus.busy) begin
          fall_cyc = cyc;
          check_val("busy_clks", cyc - rise_cyc, TWINKLE_CLKS);
          check_val("lit_clks", lit, exp_lit(rise_cyc));
          check_val("stray_led", stray, 0);
          active = 0;
          done_cnt++;
        end
      end else if (bus.led != '0) begin
        idle_led++;
      end
    end
  end

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) check_val("twinkle_timeout", done_cnt, target);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.busy) check_val("busy_timeout", 0, 1);
  endtask

  task automatic quiet_window(input string tag, input int clks);
    int b0, i0;
    b0 = busy_clks;
    i0 = idle_led;
    repeat (clks) @(negedge clk);
    check_val({tag, "_busy"}, busy_clks - b0, 0);
    check_val({tag, "_led"}, idle_led - i0, 0);
  endtask

  task automatic queue_pick(input int word);
    bus.lfsr = 4'(word);
    exp_q.push_back(map_idx(word, exp_last));
    exp_last = map_idx(word, exp_last);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.lfsr   = 4'd0;
    repeat (2) @(negedge clk);
    check_val("rst_led", int'(bus.led), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_idx", int'(bus.cur_idx), 0);

    // Enabled but held in reset: nothing may happen.
    bus.enable = 1'b1;
    bus.lfsr   = 4'b1010;
    repeat (10) @(negedge clk);
    check_val("rst_hold_led", int'(bus.led), 0);
    check_val("rst_hold_busy", int'(bus.busy), 0);
    check_val("rst_hold_idx", int'(bus.cur_idx), 0);

    // First twinkle: lfsr=10 -> LED 2, finishing 132 clks after release.
    queue_pick(4'b1010);
    reset = 1'b0;
    wait_done(1);
    check_val("first_fall_cyc", fall_cyc, (1 + MX + HT + MX) * TD);

    // Same word again: raw 2 collides with last pick, so LED 3.
    queue_pick(4'b1010);
    wait_done(2);
    bus.enable = 1'b0;

    quiet_window("idle_disabled", 20 * TD);

    // Top of the word range folds to LED 7; enable dropped mid-rise must not abort.
    queue_pick(4'd15);
    bus.enable = 1'b1;
    wait_busy();
    repeat (6) @(negedge clk);
    bus.enable = 1'b0;
    wait_done(3);
    quiet_window("after_drop", 20 * TD);

    // Reset mid-HOLD clears outputs immediately, without a clock edge.
    queue_pick(4'd3);
    bus.enable = 1'b1;
    wait_busy();
    repeat (66) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("async_led", int'(bus.led), 0);
    check_val("async_busy", int'(bus.busy), 0);
    check_val("async_idx", int'(bus.cur_idx), 0);
    exp_last = 0;
    @(negedge clk);
    // lfsr=8 folds to 0, equal to the cleared last index, so LED 1.
    queue_pick(4'd8);
    @(negedge clk);
    reset = 1'b0;
    wait_done(4);
    // lfsr=9 folds to 1, equal to the previous pick, so LED 2.
    queue_pick(4'd9);
    wait_done(5);
    bus.enable = 1'b0;
    quiet_window("final_idle", 10 * TD);

    check_val("queue_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
